pipe_ctrl: RTL and testbench

Registered pipeline control unit for the 4-stage (ID/EX/MEM/WB) core. It decodes the instruction type/opcode at ID into a control bundle and carries that bundle through ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards and multi-cycle MUL occupancy, and resolves branch/jump redirects from EX with IF/ID and ID/EX flush. It replaces the purely combinational decoder at the centre of the datapath.

---
 rtl/pipe_pkg.sv | 110 +++++++++++
 rtl/pipe_ctrl_hazard_unit.sv | 38 +++
 rtl/pipe_ctrl.sv | 103 ++++++++++
 tb/tb_pipe_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: instruction type/opcode codes, control bundle and decoder shared by
// pipe_ctrl, the datapath and the testbench.
package pipe_pkg;
   localparam int OPC_W = 4;

   typedef enum logic [1:0] {T_R, T_I, T_M, T_B} itype_e;

   localparam logic [OPC_W-1:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                                OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SLT = 4'd7,
                                OP_MUL = 4'd8;
   localparam logic [OPC_W-1:0] OP_ADDI = 4'd0, OP_ANDI = 4'd2, OP_ORI = 4'd3, OP_XORI = 4'd4,
                                OP_LUI = 4'd9, OP_JMP = 4'd10;
   localparam logic [OPC_W-1:0] OP_LW = 4'd0, OP_STW = 4'd1;
   localparam logic [OPC_W-1:0] OP_BEQ = 4'd0, OP_BNE = 4'd1;

   localparam logic [3:0] ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3,
                          ALU_OR = 4'd4, ALU_XOR = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7,
                          ALU_SLT = 4'd8, ALU_MUL = 4'd9, ALU_PASSB = 4'd10;

   localparam logic [1:0] IMM_I = 2'd0, IMM_S = 2'd1, IMM_B = 2'd2, IMM_U = 2'd3;

   // mux1: 0 = rs1, 1 = pc; mux2: 0 = rs2, 1 = imm; mux3: 0 = alu, 1 = pc+4 (link)
   typedef struct packed {
      logic       reg_wen;
      logic       mux1;
      logic       mux2;
      logic [3:0] alu_sel;
      logic       mux3;
      logic       dmem_wen;
      logic       wb_sel;
      logic       is_load;
      logic       is_mul;
      logic       is_branch;
      logic       is_jump;
      logic       uses_rs1;
      logic       uses_rs2;
   } ctrl_t;

   function automatic ctrl_t decode(logic [1:0] t, logic [OPC_W-1:0] op);
      ctrl_t c;
      c = '0;
      case (t)
         T_R: if (op <= OP_MUL) begin
            c.reg_wen  = 1'b1;
            c.alu_sel  = op + ALU_ADD;
            c.wb_sel   = 1'b1;
            c.is_mul   = op == OP_MUL;
            c.uses_rs1 = 1'b1;
            c.uses_rs2 = 1'b1;
         end
         T_I: case (op)
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
               c.reg_wen  = 1'b1;
               c.mux2     = 1'b1;
               c.alu_sel  = op + ALU_ADD;
               c.wb_sel   = 1'b1;
               c.uses_rs1 = 1'b1;
            end
            OP_LUI: begin
               c.reg_wen = 1'b1;
               c.mux2    = 1'b1;
               c.alu_sel = ALU_PASSB;
               c.wb_sel  = 1'b1;
            end
            OP_JMP: begin
               c.reg_wen = 1'b1;
               c.mux1    = 1'b1;
               c.mux2    = 1'b1;
               c.alu_sel = ALU_ADD;
               c.mux3    = 1'b1;
               c.wb_sel  = 1'b1;
               c.is_jump = 1'b1;
            end
            default: c = '0;
         endcase
         T_M: case (op)
            OP_LW: begin
               c.reg_wen  = 1'b1;
               c.mux2     = 1'b1;
               c.alu_sel  = ALU_ADD;
               c.is_load  = 1'b1;
               c.uses_rs1 = 1'b1;
            end
            OP_STW: begin
               c.mux2     = 1'b1;
               c.alu_sel  = ALU_ADD;
               c.dmem_wen = 1'b1;
               c.uses_rs1 = 1'b1;
               c.uses_rs2 = 1'b1;
            end
            default: c = '0;
         endcase
         default: if (op == OP_BEQ || op == OP_BNE) begin
            c.mux1      = 1'b1;
            c.mux2      = 1'b1;
            c.alu_sel   = ALU_ADD;
            c.is_branch = 1'b1;
            c.uses_rs1  = 1'b1;
            c.uses_rs2  = 1'b1;
         end
      endcase
      return c;
   endfunction

   function automatic logic [1:0] imm_sel(logic [1:0] t, logic [OPC_W-1:0] op);
      return (t == T_I) ? (op == OP_LUI ? IMM_U : op == OP_JMP ? IMM_B : IMM_I) :
             (t == T_M) ? (op == OP_STW ? IMM_S : IMM_I) :
             (t == T_B) ? IMM_B : IMM_I;
   endfunction
endpackage

// File: rtl/pipe_ctrl_hazard_unit.sv
// hazard_unit: combinational load-use, MUL-busy and redirect detection with
// priority redirect > MUL busy > load-use.
module hazard_unit
   import pipe_pkg::*;
#(
   parameter int RA_W = 4
) (
   input  logic            id_valid,
   input  logic            id_uses_rs1,
   input  logic            id_uses_rs2,
   input  logic [RA_W-1:0] id_rs1,
   input  logic [RA_W-1:0] id_rs2,
   input  logic            ex_valid,
   input  logic            ex_is_load,
   input  logic            ex_is_branch,
   input  logic            ex_is_jump,
   input  logic [RA_W-1:0] ex_rd,
   input  logic            ex_br_cond,
   input  logic            mul_busy,
   output logic            stall,
   output logic            flush,
   output logic            redirect,
   output logic            hold_ex,
   output logic            bubble_ex,
   output logic            bubble_mem
);
   logic load_use;

   assign redirect = ex_valid & (ex_is_jump | (ex_is_branch & ex_br_cond));
   assign load_use = ex_valid & ex_is_load & (ex_rd != '0) & id_valid &
                     ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

   assign flush      = redirect;
   assign stall      = ~redirect & (mul_busy | load_use);
   assign hold_ex    = ~redirect & mul_busy;
   assign bubble_mem = ~redirect & mul_busy;
   assign bubble_ex  = redirect | (~mul_busy & load_use);
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: decodes at ID and carries the control bundle through ID/EX, EX/MEM
// and MEM/WB, applying load-use, MUL-occupancy and branch/jump redirect control.
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int OP_W    = 4,
   parameter int RA_W    = 4,
   parameter int MUL_LAT = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [1:0]      id_type,
   input  logic [OP_W-1:0] id_op,
   input  logic [RA_W-1:0] id_rs1,
   input  logic [RA_W-1:0] id_rs2,
   input  logic [RA_W-1:0] id_rd,
   input  logic            ex_br_cond,
   output logic            stall_out,
   output logic            flush_out,
   output logic            redirect_out,
   output logic [1:0]      id_imm_sel,
   output logic            ex_mux1_sel,
   output logic            ex_mux2_sel,
   output logic            ex_mux3_sel,
   output logic [3:0]      ex_alu_sel,
   output logic            mem_dmem_wen,
   output logic            wb_reg_wen,
   output logic            wb_sel,
   output logic [RA_W-1:0] wb_rd
);
   localparam int CNT_W = $clog2(MUL_LAT + 1);

   typedef struct packed {
      logic            valid;
      ctrl_t           c;
      logic [RA_W-1:0] rd;
   } stage_t;

   stage_t          id_next, id_ex, ex_mem, mem_wb;
   logic [CNT_W-1:0] mul_cnt;
   logic            mul_busy, hold_ex, bubble_ex, bubble_mem;
   logic            unused_bits;

   always_comb begin
      id_next           = '0;
      id_next.valid     = id_valid;
      id_next.c         = decode(id_type, OPC_W'(id_op));
      id_next.c.reg_wen = id_next.c.reg_wen & (id_rd != '0);
      id_next.rd        = id_rd;
   end

   assign mul_busy = mul_cnt != '0;

   hazard_unit #(.RA_W(RA_W)) u_hazard (
      .id_valid    (id_valid),
      .id_uses_rs1 (id_next.c.uses_rs1),
      .id_uses_rs2 (id_next.c.uses_rs2),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .ex_valid    (id_ex.valid),
      .ex_is_load  (id_ex.c.is_load),
      .ex_is_branch(id_ex.c.is_branch),
      .ex_is_jump  (id_ex.c.is_jump),
      .ex_rd       (id_ex.rd),
      .ex_br_cond  (ex_br_cond),
      .mul_busy    (mul_busy),
      .stall       (stall_out),
      .flush       (flush_out),
      .redirect    (redirect_out),
      .hold_ex     (hold_ex),
      .bubble_ex   (bubble_ex),
      .bubble_mem  (bubble_mem)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_ex   <= '0;
         ex_mem  <= '0;
         mem_wb  <= '0;
         mul_cnt <= '0;
      end else begin
         mem_wb <= ex_mem;
         ex_mem <= bubble_mem ? '0 : id_ex;
         if (!hold_ex) id_ex <= bubble_ex ? '0 : id_next;
         // the counter is armed only when a MUL actually lands in ID/EX
         if (mul_busy) mul_cnt <= mul_cnt - 1'b1;
         else if (!bubble_ex && id_next.valid && id_next.c.is_mul) mul_cnt <= CNT_W'(MUL_LAT - 1);
      end
   end

   assign id_imm_sel   = imm_sel(id_type, OPC_W'(id_op));
   assign ex_mux1_sel  = id_ex.valid & id_ex.c.mux1;
   assign ex_mux2_sel  = id_ex.valid & id_ex.c.mux2;
   assign ex_mux3_sel  = id_ex.valid & id_ex.c.mux3;
   assign ex_alu_sel   = id_ex.valid ? id_ex.c.alu_sel : ALU_NOP;
   assign mem_dmem_wen = ex_mem.valid & ex_mem.c.dmem_wen;
   assign wb_reg_wen   = mem_wb.valid & mem_wb.c.reg_wen;
   assign wb_sel       = mem_wb.valid & mem_wb.c.wb_sel;
   assign wb_rd        = mem_wb.valid ? mem_wb.rd : '0;

   assign unused_bits = ^{id_ex, ex_mem, mem_wb};
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed programs against an instruction-level pipeline model,
// plus hand-computed cycle-exact expectations.
module tb_pipe_ctrl;
   import pipe_pkg::*;
   localparam int MUL_LAT = 3;

   logic       clk = 0, rst = 0;
   logic       id_valid = 0, ex_br_cond = 0;
   logic [1:0] id_type = 0;
   logic [3:0] id_op = 0, id_rs1 = 0, id_rs2 = 0, id_rd = 0;
   logic       stall_out, flush_out, redirect_out, ex_mux1_sel, ex_mux2_sel, ex_mux3_sel;
   logic       mem_dmem_wen, wb_reg_wen, wb_sel;
   logic [1:0] id_imm_sel;
   logic [3:0] ex_alu_sel, wb_rd;

   always #5 clk = ~clk;

   pipe_ctrl #(.OP_W(4), .RA_W(4), .MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_type(id_type), .id_op(id_op),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_br_cond(ex_br_cond),
      .stall_out(stall_out), .flush_out(flush_out), .redirect_out(redirect_out),
      .id_imm_sel(id_imm_sel), .ex_mux1_sel(ex_mux1_sel), .ex_mux2_sel(ex_mux2_sel),
      .ex_mux3_sel(ex_mux3_sel), .ex_alu_sel(ex_alu_sel), .mem_dmem_wen(mem_dmem_wen),
      .wb_reg_wen(wb_reg_wen), .wb_sel(wb_sel), .wb_rd(wb_rd)
   );

   typedef struct packed {
      logic v; logic [1:0] t; logic [3:0] op, rd, rs1, rs2; logic cond;
   } ins_t;
   typedef struct packed {
      logic rw, dw, wbs, ld, mul, br, jmp, u1, u2, m1, m2, m3; logic [3:0] alu; logic [1:0] imm;
   } props_t;

   int n_cmp = 0, n_bad = 0;
   int idx = 0, cyc = 0, occ = 0, mulw = 0, addw = 0;
   bit fl_pend = 0, from_prog = 0;
   ins_t prog[$];
   ins_t cur = '0, ex_s = '0, mem_s = '0, wb_s = '0;
   props_t pe, pm, pw, pi;
   bit redir, busy, lu, st;

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic ins_t mk(logic [1:0] t, logic [3:0] op, logic [3:0] rd, logic [3:0] rs1,
                               logic [3:0] rs2, logic c = 1'b0);
      return '{v: 1'b1, t: t, op: op, rd: rd, rs1: rs1, rs2: rs2, cond: c};
   endfunction

   // What each instruction must do, written mnemonic by mnemonic.
   function automatic props_t spec_of(ins_t i);
      props_t p;
      p = '0;
      if (!i.v) return p;
      if (i.t == T_R && i.op <= OP_MUL) begin
         p.rw = 1; p.wbs = 1; p.u1 = 1; p.u2 = 1; p.mul = (i.op == OP_MUL); p.alu = i.op + 4'd1;
      end else if (i.t == T_I && (i.op == OP_ADDI || i.op == OP_ANDI || i.op == OP_ORI || i.op == OP_XORI)) begin
         p.rw = 1; p.wbs = 1; p.u1 = 1; p.m2 = 1; p.alu = i.op + 4'd1;
      end else if (i.t == T_I && i.op == OP_LUI) begin
         p.rw = 1; p.wbs = 1; p.m2 = 1; p.alu = ALU_PASSB; p.imm = IMM_U;
      end else if (i.t == T_I && i.op == OP_JMP) begin
         p.rw = 1; p.wbs = 1; p.m1 = 1; p.m2 = 1; p.m3 = 1; p.jmp = 1; p.alu = ALU_ADD; p.imm = IMM_B;
      end else if (i.t == T_M && i.op == OP_LW) begin
         p.rw = 1; p.ld = 1; p.u1 = 1; p.m2 = 1; p.alu = ALU_ADD;
      end else if (i.t == T_M && i.op == OP_STW) begin
         p.dw = 1; p.u1 = 1; p.u2 = 1; p.m2 = 1; p.alu = ALU_ADD; p.imm = IMM_S;
      end else if (i.t == T_B && (i.op == OP_BEQ || i.op == OP_BNE)) begin
         p.br = 1; p.u1 = 1; p.u2 = 1; p.m1 = 1; p.m2 = 1; p.alu = ALU_ADD; p.imm = IMM_B;
      end
      return p;
   endfunction

   function automatic logic [1:0] imm_of(ins_t i);
      ins_t j;
      j = i;
      j.v = 1'b1;
      return spec_of(j).imm;
   endfunction

   // Model: compare this cycle, then advance to the state after the coming edge.
   always @(negedge clk) begin
      if (rst) begin
         ex_s = '0; mem_s = '0; wb_s = '0; occ = 0; fl_pend = 0; idx = prog.size();
      end else begin
         pe = spec_of(ex_s); pm = spec_of(mem_s); pw = spec_of(wb_s); pi = spec_of(cur);
         redir = ex_s.v && (pe.jmp || (pe.br && ex_s.cond));
         busy  = ex_s.v && pe.mul && occ < MUL_LAT - 1;
         lu    = ex_s.v && pe.ld && ex_s.rd != 0 && cur.v &&
                 ((pi.u1 && cur.rs1 == ex_s.rd) || (pi.u2 && cur.rs2 == ex_s.rd));
         st    = !redir && (busy || lu);
         check("m_stall", stall_out, st);
         check("m_flush", flush_out, redir);
         check("m_redirect", redirect_out, redir);
         check("m_imm", id_imm_sel, imm_of(cur));
         check("m_ex_alu", ex_alu_sel, pe.alu);
         check("m_ex_mux", {ex_mux1_sel, ex_mux2_sel, ex_mux3_sel}, {pe.m1, pe.m2, pe.m3});
         check("m_mem_wen", mem_dmem_wen, pm.dw);
         check("m_wb_wen", wb_reg_wen, pw.rw && wb_s.rd != 0);
         check("m_wb_sel", wb_sel, pw.wbs);
         check("m_wb_rd", wb_rd, wb_s.v ? wb_s.rd : 4'd0);
         wb_s = mem_s;
         if (redir) begin mem_s = ex_s; ex_s = '0; occ = 0; end
         else if (busy) begin mem_s = '0; occ++; end
         else if (lu) begin mem_s = ex_s; ex_s = '0; end
         else begin mem_s = ex_s; ex_s = cur; occ = 0; end
         if (from_prog && !st) idx++;
         fl_pend = redir;
      end
   end

   task automatic drive();
      @(posedge clk);
      #1;
      rst = 0;
      from_prog = !fl_pend && idx < prog.size();
      cur = from_prog ? prog[idx] : '0;
      id_valid = cur.v; id_type = cur.t; id_op = cur.op;
      id_rs1 = cur.rs1; id_rs2 = cur.rs2; id_rd = cur.rd;
      ex_br_cond = ex_s.v & ex_s.cond;
      cyc++;
   endtask

   task automatic pins(int s, int c);
      case (s)
         1: begin
            if (c == 1) check("add_ex_alu", ex_alu_sel, ALU_ADD);
            if (c == 2) check("add_wb_early", wb_reg_wen, 0);
            if (c == 3) begin
               check("add_wb_wen", wb_reg_wen, 1); check("add_wb_sel", wb_sel, 1); check("add_wb_rd", wb_rd, 3);
            end
         end
         2: begin
            if (c == 1) check("lu_stall", stall_out, 1);
            if (c == 2) begin check("lu_stall_end", stall_out, 0); check("lu_bubble", ex_alu_sel, ALU_NOP); end
            if (c == 3) begin
               check("lu_add_ex", ex_alu_sel, ALU_ADD); check("lw_wb_rd", wb_rd, 5); check("lw_wb_sel", wb_sel, 0);
            end
            if (c == 5) begin check("lu_add_wb_rd", wb_rd, 6); check("lu_add_wb_wen", wb_reg_wen, 1); end
         end
         3: begin
            if (wb_reg_wen && wb_rd == 7) mulw++;
            if (wb_reg_wen && wb_rd == 8) addw++;
            if (c == 1 || c == 2) check("mul_stall", stall_out, 1);
            if (c == 3) begin check("mul_stall_end", stall_out, 0); check("mul_ex_alu", ex_alu_sel, ALU_MUL); end
            if (c == 4) check("mul_bubble_wb", wb_reg_wen, 0);
            if (c == 5) check("mul_wb_rd", wb_rd, 7);
            if (c == 6) check("mul_add_wb_rd", wb_rd, 8);
         end
         4: begin
            if (c == 1) begin
               check("br_redirect", redirect_out, 1); check("br_flush", flush_out, 1); check("br_no_stall", stall_out, 0);
            end
            if (c == 2) check("br_bubble1", ex_alu_sel, ALU_NOP);
            if (c == 3) begin check("br_bubble2", ex_alu_sel, ALU_NOP); check("br_mem1", mem_dmem_wen, 0); end
            if (c == 4) begin check("br_mem2", mem_dmem_wen, 0); check("br_target_ex", ex_alu_sel, ALU_ADD); end
         end
         5: begin
            if (c == 1) begin check("nt_redirect", redirect_out, 0); check("nt_flush", flush_out, 0); end
            if (c == 3) check("nt_store", mem_dmem_wen, 1);
         end
         6: begin
            if (c == 1) check("r0_ex_alu", ex_alu_sel, ALU_ADD);
            if (c == 2) begin check("undef_alu", ex_alu_sel, 0); check("undef_mux2", ex_mux2_sel, 0); end
            if (c == 3) check("r0_wb_wen", wb_reg_wen, 0);
            if (c == 4) check("undef_wb_wen", wb_reg_wen, 0);
            if (c == 5) begin check("addi_wb_wen", wb_reg_wen, 1); check("addi_wb_rd", wb_rd, 4); end
         end
         7: if (c == 1) begin
            check("rst_mul_stall", stall_out, 1);
            #1 rst = 1;
            #1;
            check("rst_stall", stall_out, 0); check("rst_alu", ex_alu_sel, 0);
            check("rst_mem", mem_dmem_wen, 0); check("rst_wb", wb_reg_wen, 0);
         end
         default: begin
            if (c == 1 || c == 2 || c == 3) check("nohaz_stall", stall_out, 0);
            if (c == 5) begin check("jmp_redirect", redirect_out, 1); check("jmp_mux3", ex_mux3_sel, 1); end
         end
      endcase
   endtask

   task automatic run(int s, int n);
      idx = 0; cyc = -1; mulw = 0; addw = 0;
      repeat (n) begin
         drive();
         #1 pins(s, cyc);
      end
   endtask

   initial begin
      #1 rst = 1;
      #2;
      check("reset_stall", stall_out, 0);
      check("reset_flush", flush_out, 0);
      check("reset_redirect", redirect_out, 0);
      check("reset_alu", ex_alu_sel, 0);
      check("reset_mem", mem_dmem_wen, 0);
      check("reset_wb_wen", wb_reg_wen, 0);
      check("reset_wb_rd", wb_rd, 0);
      prog = '{mk(T_R, OP_ADD, 3, 1, 2)};
      run(1, 10);
      prog = '{mk(T_M, OP_LW, 5, 1, 0), mk(T_R, OP_ADD, 6, 5, 1)};
      run(2, 10);
      prog = '{mk(T_R, OP_MUL, 7, 1, 2), mk(T_R, OP_ADD, 8, 7, 3)};
      run(3, 10);
      check("mul_wb_once", mulw, 1);
      check("add_wb_once", addw, 1);
      prog = '{mk(T_B, OP_BEQ, 0, 1, 2, 1'b1), mk(T_M, OP_STW, 0, 1, 2), mk(T_I, OP_ADDI, 9, 1, 0)};
      run(4, 10);
      prog = '{mk(T_B, OP_BEQ, 0, 1, 2, 1'b0), mk(T_M, OP_STW, 0, 1, 2)};
      run(5, 10);
      prog = '{mk(T_I, OP_ADDI, 0, 1, 0), mk(T_R, 4'd15, 5, 1, 2), mk(T_I, OP_ADDI, 4, 1, 0)};
      run(6, 10);
      prog = '{mk(T_R, OP_MUL, 7, 1, 2), mk(T_R, OP_ADD, 8, 7, 3)};
      run(7, 5);
      prog = '{mk(T_R, OP_ADD, 3, 1, 2)};
      run(1, 10);
      prog = '{mk(T_M, OP_LW, 0, 1, 0), mk(T_R, OP_ADD, 6, 0, 1), mk(T_M, OP_LW, 5, 1, 0),
               mk(T_I, OP_LUI, 6, 5, 5), mk(T_I, OP_JMP, 1, 0, 0), mk(T_R, OP_ADD, 2, 1, 1)};
      run(8, 12);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
